// File: rtl/disp_scanner.sv
// rtl/disp_scanner.sv - debug 7-segment scanner with debounced next/prev register select
// Optional feature macro: DISP_SCANNER_SELSHOW_EN (register number on digits 7..6)
module disp_scanner #(
  parameter int REFRESH_DIV     = 1000,
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_prev,
  output logic [4:0]  dispSel,
  input  logic [31:0] dispDat,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [2:0]    D_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [RW-1:0] rcnt;
  logic [2:0]    didx;
  logic [31:0]   shadow;
  logic          load_pending;
  logic [1:0]    meta, sync, stable, armed, rise;
  logic [DW-1:0] cnt [2];
  logic          frame_end, load, sel_change;
  logic [3:0]    nibble;
  logic          dp_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign frame_end  = (rcnt == R_LAST) && (didx == D_LAST);
  assign load       = load_pending || frame_end;
  assign sel_change = rise[0] ^ rise[1];

  // Synchronizers track the pins through reset so the arm logic sees the true level.
  always_ff @(posedge clk) begin
    meta <= {btn_prev, btn_next};
    sync <= meta;
  end

  // armed blocks a press that was already held across reset until it is released.
  always_comb begin
    rise = '0;
    for (int b = 0; b < 2; b++)
      rise[b] = armed[b] && !stable[b] && sync[b] && (cnt[b] == DB_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      armed  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        armed[b] <= armed[b] | ~sync[b];
        if (sync[b] != stable[b]) begin
          if (cnt[b] == DB_LAST) begin
            stable[b] <= sync[b];
            cnt[b]    <= '0;
          end else begin
            cnt[b] <= cnt[b] + DW'(1);
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dispSel      <= '0;
      rcnt         <= '0;
      didx         <= '0;
      shadow       <= '0;
      load_pending <= 1'b1;
    end else begin
      case (rise)
        2'b01:   dispSel <= dispSel + 5'd1;
        2'b10:   dispSel <= dispSel - 5'd1;
        default: dispSel <= dispSel;
      endcase
      if (rcnt == R_LAST) begin
        rcnt <= '0;
        didx <= (didx == D_LAST) ? 3'd0 : didx + 3'd1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      if (load)
        shadow <= dispDat;
      if (sel_change)
        load_pending <= 1'b1;
      else if (load)
        load_pending <= 1'b0;
    end
  end

  always_comb begin
    nibble  = shadow[{didx, 2'b00} +: 4];
    dp_next = 1'b1;
`ifdef DISP_SCANNER_SELSHOW_EN
    if (didx == 3'd7) begin
      nibble = {3'b000, dispSel[4]};
    end else if (didx == 3'd6) begin
      nibble  = dispSel[3:0];
      dp_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << didx);
      seg <= hex7(nibble);
      dp  <= dp_next;
    end
  end
endmodule
